// File: rtl/alu_mul_ctrl.sv
// Shift-and-add unsigned multiplier controller that sequences an external combinational ALU.
// Optional feature macro: ALU_MUL_EARLY_EXIT_EN (finish as soon as the remaining multiplier bits are zero).
module alu_mul_ctrl #(
    parameter int         WIDTH  = 4,
    parameter logic [2:0] ADD_OC = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [2:0]           alu_oc,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [WIDTH-1:0]     alu_f
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]   mplr_reg, mplr_next;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic [CW-1:0]      cnt_reg, cnt_next;

    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH:0]   step_wide;
    logic [2*WIDTH-1:0] shifted;

    // The ALU wraps mod 2^WIDTH, so a wrapped sum is smaller than the accumulator it started from.
    always_comb begin
        if (mplr_reg[0]) begin
            sum   = alu_f;
            carry = (alu_f < acc_reg);
        end else begin
            sum   = acc_reg;
            carry = 1'b0;
        end
    end

    assign step_wide = {carry, sum, mplr_reg};
    assign shifted   = step_wide[2*WIDTH:1];

`ifdef ALU_MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0]   rem_mask;
    logic               rem_zero;
    logic [2*WIDTH-1:0] aligned;

    // After step cnt, the low WIDTH-1-cnt bits of the shifted multiplier are still unconsumed.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rem_mask
            assign rem_mask[gi] = (gi < (WIDTH - 1 - int'(cnt_reg)));
        end
    endgenerate

    assign rem_zero = ((shifted[WIDTH-1:0] & rem_mask) == '0);
    assign aligned  = shifted >> (WIDTH - 1 - int'(cnt_reg));
`endif

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        mplr_next  = mplr_reg;
        mcand_next = mcand_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    mcand_next = a;
                    mplr_next  = b;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = STEP;
`ifdef ALU_MUL_EARLY_EXIT_EN
                    if (b == '0) begin
                        state_next = DONE;
                    end
`endif
                end
            end
            STEP: begin
                {acc_next, mplr_next} = shifted;
                cnt_next              = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = DONE;
                end
`ifdef ALU_MUL_EARLY_EXIT_EN
                else if (rem_zero) begin
                    // Skip the remaining pure-shift steps by aligning in one go.
                    {acc_next, mplr_next} = aligned;
                    state_next            = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            mplr_reg  <= '0;
            mcand_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            mplr_reg  <= mplr_next;
            mcand_reg <= mcand_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign product   = {acc_reg, mplr_reg};
    assign alu_oc    = ADD_OC;
    assign alu_a     = acc_reg;
    assign alu_b     = mcand_reg;

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Directed testbench for alu_mul_ctrl with a behavioural 4-bit ALU attached to its ALU port.
// Expected latencies follow ALU_MUL_EARLY_EXIT_EN when the bench is built with it.
module tb_alu_mul_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [2*W-1:0] product;
    logic [2:0]   alu_oc;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_f;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mul_ctrl #(.WIDTH(W), .ADD_OC(3'b000)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .alu_oc    (alu_oc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f)
    );

    // Only the add opcode yields a sum; anything else gives a wrong value on purpose.
    assign alu_f = (alu_oc == 3'b000) ? (alu_a + alu_b) : (alu_a ^ alu_b);

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [W-1:0] bv);
        int m;
        m = -1;
        for (int i = 0; i < W; i++) if (bv[i]) m = i;
`ifdef ALU_MUL_EARLY_EXIT_EN
        return m + 1;
`else
        return (m >= -1) ? W : 0;
`endif
    endfunction

    // Offers one operand pair, waits for acceptance and for out_valid; lat=-2 accept timeout, -1 result timeout.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output logic [2*W-1:0] prod, output time acc_t);
        logic got;
        got   = 1'b0;
        lat   = -2;
        prod  = '0;
        acc_t = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                @(posedge clk);
                acc_t = $time;
                got   = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        #1;
        in_valid = 1'b0;
        if (!got) return;
        lat = -1;
        if (out_valid) begin
            lat = 0;
        end else begin
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) begin
                    lat = k;
                    break;
                end
            end
        end
        prod = product;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (product !== 8'h00) begin n_fail++; $display("FAIL reset_product got=%h exp=00", product); end
        n_checks++; if (alu_a !== 4'h0) begin n_fail++; $display("FAIL reset_alu_a got=%h exp=0", alu_a); end
        n_checks++; if (alu_b !== 4'h0) begin n_fail++; $display("FAIL reset_alu_b got=%h exp=0", alu_b); end
        n_checks++; if (alu_oc !== 3'b000) begin n_fail++; $display("FAIL reset_alu_oc got=%b exp=000", alu_oc); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        a = 4'd15;
        b = 4'd15;
        in_valid = 1'b1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (alu_b !== 4'd15) begin n_fail++; $display("FAIL basic_mcand got=%h exp=f", alu_b); end
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (alu_oc !== 3'b000) begin n_fail++; $display("FAIL basic_alu_oc edge=%0d got=%b exp=000", k - 1, alu_oc); end
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== (k == 4)) begin
                n_fail++; $display("FAIL basic_out_valid edge=%0d got=%b exp=%b", k, out_valid, (k == 4));
            end
        end
        $display("basic: a=15 b=15 product=%h", product);
        n_checks++; if (product !== 8'hE1) begin n_fail++; $display("FAIL basic_product got=%h exp=e1", product); end
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle got=%b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
    endtask

    task automatic test_sweep();
        int lat, prev_lat;
        logic [2*W-1:0] prod, expp;
        logic [W-1:0] av, bv;
        time t, prev_t;
        prev_lat = 0;
        prev_t   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            av = 4'(i >> 4);
            bv = 4'(i);
            expp = {4'b0, av} * {4'b0, bv};
            run_op(av, bv, lat, prod, t);
            $display("sweep: a=%0d b=%0d product=%0d latency=%0d", av, bv, prod, lat);
            n_checks++; if (prod !== expp) begin n_fail++; $display("FAIL sweep_product a=%0d b=%0d got=%0d exp=%0d", av, bv, prod, expp); end
            n_checks++; if (lat != exp_lat(bv)) begin n_fail++; $display("FAIL sweep_latency a=%0d b=%0d got=%0d exp=%0d", av, bv, lat, exp_lat(bv)); end
            if (i > 0) begin
                n_checks++;
                if ((t - prev_t) != 10 * (prev_lat + 2)) begin
                    n_fail++; $display("FAIL sweep_ii a=%0d b=%0d got=%0t exp=%0d cycles", av, bv, (t - prev_t) / 10, prev_lat + 2);
                end
            end
            prev_t   = t;
            prev_lat = lat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_early_exit();
        int lat;
        logic [2*W-1:0] prod;
        time t;
        out_ready = 1'b1;
        run_op(4'd7, 4'd1, lat, prod, t);
        $display("early: a=7 b=1 product=%0d latency=%0d", prod, lat);
        n_checks++; if (prod !== 8'd7) begin n_fail++; $display("FAIL early_7x1_product got=%0d exp=7", prod); end
        n_checks++; if (lat != exp_lat(4'd1)) begin n_fail++; $display("FAIL early_7x1_latency got=%0d exp=%0d", lat, exp_lat(4'd1)); end
        run_op(4'd9, 4'd0, lat, prod, t);
        $display("early: a=9 b=0 product=%0d latency=%0d", prod, lat);
        n_checks++; if (prod !== 8'd0) begin n_fail++; $display("FAIL early_9x0_product got=%0d exp=0", prod); end
        n_checks++; if (lat != exp_lat(4'd0)) begin n_fail++; $display("FAIL early_9x0_latency got=%0d exp=%0d", lat, exp_lat(4'd0)); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2*W-1:0] prod;
        time t;
        out_ready = 1'b0;
        run_op(4'd3, 4'd5, lat, prod, t);
        $display("backpressure: a=3 b=5 product=%0d latency=%0d", prod, lat);
        n_checks++; if (prod !== 8'd15) begin n_fail++; $display("FAIL bp_product got=%0d exp=15", prod); end
        n_checks++; if (lat != exp_lat(4'd5)) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", lat, exp_lat(4'd5)); end
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin a = 4'd1; b = 4'd1; in_valid = 1'b1; end
            if (k == 4) in_valid = 1'b0;
            @(posedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cycle=%0d got=%b exp=1", k, out_valid); end
            n_checks++; if (product !== 8'd15) begin n_fail++; $display("FAIL bp_hold cycle=%0d got=%0d exp=15", k, product); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", k, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pulse_ignored got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [2*W-1:0] prod;
        time t;
        out_ready = 1'b1;
        a = 4'd12;
        b = 4'd11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (product !== 8'h00) begin n_fail++; $display("FAIL mid_rst_product got=%h exp=00", product); end
        n_checks++; if (alu_a !== 4'h0) begin n_fail++; $display("FAIL mid_rst_alu_a got=%h exp=0", alu_a); end
        n_checks++; if (alu_b !== 4'h0) begin n_fail++; $display("FAIL mid_rst_alu_b got=%h exp=0", alu_b); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_partial got=%b exp=0", out_valid); end
        run_op(4'd2, 4'd3, lat, prod, t);
        $display("after reset: a=2 b=3 product=%0d latency=%0d", prod, lat);
        n_checks++; if (prod !== 8'd6) begin n_fail++; $display("FAIL mid_rst_next_product got=%0d exp=6", prod); end
        n_checks++; if (lat != exp_lat(4'd3)) begin n_fail++; $display("FAIL mid_rst_next_latency got=%0d exp=%0d", lat, exp_lat(4'd3)); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_basic();
        test_sweep();
        test_early_exit();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
